// File: rtl/sum_accum_ctrl.sv
// Array-sum controller: sequences INIT/ACCUM/DONE and drives the selector and the word address.
// It also holds the running sum, which is loaded from the external selector output.
module sum_accum_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [WIDTH-1:0]      mux_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mux_sel,
    output logic [WIDTH-1:0]      sum,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      sum_q, sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        mux_sel = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Requests longer than the memory are clamped to a full sweep.
                    len_d   = (len > MAX_LEN) ? MAX_LEN : len;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                busy    = 1'b1;
                sum_d   = mux_out;
                addr_d  = '0;
                cnt_d   = '0;
                state_d = (len_q == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                busy    = 1'b1;
                mux_sel = 1'b1;
                sum_d   = mux_out;
                cnt_d   = cnt_q + ONE;
                // Wraps to 0 after the last word of a full sweep; that value is never read.
                addr_d  = addr_q + 1'b1;
                if (cnt_q == len_q - ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr = addr_q;
    assign sum      = sum_q;

endmodule

// File: tb/tb_sum_accum_ctrl.sv
// Bench for sum_accum_ctrl: a local memory and selector, a cycle-indexed run model, and directed runs.
module tb_sum_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic [31:0] mux_out;
    logic [3:0]  mem_addr;
    logic        mux_sel;
    logic [31:0] sum;
    logic        busy;
    logic        done;

    logic [31:0] mem [16];

    int nchecks = 0;
    int nerr    = 0;

    sum_accum_ctrl #(.WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .mux_out  (mux_out),
        .mem_addr (mem_addr),
        .mux_sel  (mux_sel),
        .sum      (sum),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Upstream selector and adder with asynchronous memory read.
    assign mux_out = mux_sel ? (sum + mem[mem_addr]) : 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] partial(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < n; i++) s = s + mem[i];
        return s;
    endfunction

    // Run model: m_k counts cycles since the start edge (1 = INIT, L+2 = DONE).
    bit          m_act;
    int          m_k;
    int          m_L;
    logic [31:0] m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  = 1'b0;
            m_k    = 0;
            m_L    = 0;
            m_hold = 32'd0;
        end else if (m_act) begin
            if (m_k == m_L + 2) begin
                m_act  = 1'b0;
                m_hold = partial(m_L);
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_act = 1'b1;
            m_k   = 1;
            m_L   = (len > 5'd16) ? 16 : int'(len);
        end
    end

    logic        e_busy, e_done, e_sel;
    logic [31:0] e_sum;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_sel", {31'd0, mux_sel}, 32'd0);
            chk("rst_sum", sum, 32'd0);
            chk("rst_addr", {28'd0, mem_addr}, 32'd0);
        end else begin
            e_busy = m_act && (m_k <= m_L + 1);
            e_done = m_act && (m_k == m_L + 2);
            e_sel  = m_act && (m_k >= 2) && (m_k <= m_L + 1);
            e_sum  = (!m_act || m_k == 1) ? m_hold : partial(m_k - 2);
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("mux_sel", {31'd0, mux_sel}, {31'd0, e_sel});
            chk("sum", sum, e_sum);
            if (e_sel) chk("mem_addr", {28'd0, mem_addr}, 32'(m_k - 2));
        end
    end

    // One run with literal expectations; inj > 0 pulses start (len = 1) in that cycle.
    task automatic do_run(input int l, input logic [31:0] es, input int edone, input int inj);
        int L;
        int dcnt;
        int dcyc;
        int scnt;
        int last;
        L    = (l > 16) ? 16 : l;
        dcnt = 0;
        dcyc = -1;
        scnt = 0;
        last = -1;
        @(negedge clk);
        start = 1'b1;
        len   = 5'(l);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (inj > 0 && c == inj) begin
                start = 1'b1;
                len   = 5'd1;
            end
            if (inj > 0 && c == inj + 1) start = 1'b0;
            if (mux_sel) begin
                scnt++;
                last = int'(mem_addr);
            end
            if (done) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
            if (dcyc >= 0 && c >= dcyc + 5) break;
        end
        $display("run len=%0d: sum=%0h done_cycle=%0d dones=%0d accum_cycles=%0d", l, sum, dcyc, dcnt, scnt);
        chk("run_done_cycle", 32'(dcyc), 32'(edone));
        chk("run_done_count", 32'(dcnt), 32'd1);
        chk("run_accum_cycles", 32'(scnt), 32'(L));
        chk("run_sum_held", sum, es);
        if (L > 0) chk("run_last_addr", 32'(last), 32'(L - 1));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        repeat (2) @(negedge clk);
        chk("reset_sum", sum, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_run(4, 32'd10, 6, 0);
        do_run(0, 32'd0, 2, 0);

        for (int i = 0; i < 16; i++) mem[i] = 32'd1;
        do_run(16, 32'd16, 18, 0);
        do_run(20, 32'd16, 18, 0);

        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'hFFFF_FFFF;
        do_run(2, 32'hFFFF_FFFE, 4, 0);

        for (int i = 0; i < 16; i++) mem[i] = 32'(i + 1);
        do_run(4, 32'd10, 6, 3);

        // Abort in the second ACCUM cycle with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        len   = 5'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        chk("abort_sum_before", sum, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-run: sum=%0h addr=%0h busy=%0b done=%0b", sum, mem_addr, busy, done);
        chk("abort_sum", sum, 32'd0);
        chk("abort_addr", {28'd0, mem_addr}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end

        do_run(4, 32'd10, 6, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/sum_accum_ctrl.md
Name: sum_accum_ctrl

Overview:
- Controller plus accumulator register for the array-sum datapath.
- Drives the select line of the upstream 2-to-1 selector (a = sum + mem_data, b = zero) and generates the word address.
- Registers the selector output into the running sum.
- Runs a start/done handshake with the top-level test harness.

Parameters:
WIDTH, 32, data and sum width in bits.
ADDR_WIDTH, 4, memory address width; at most 2^ADDR_WIDTH words per run.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request a new summation; sampled in IDLE only.
len  input  ADDR_WIDTH+1  number of words to sum; sampled with start.
mux_out  input  WIDTH  selector output; next value of the sum register.
mem_addr  output  ADDR_WIDTH  read address to data memory (asynchronous read, data valid same cycle).
mux_sel  output  1  1 = accumulate (selector passes a), 0 = clear (passes b = zero).
sum  output  WIDTH  accumulator register contents.
busy  output  1  high in INIT and ACCUM.
done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; sum = 0; mem_addr = 0; internal len_q = 0; word counter = 0.
  - mux_sel = 0, busy = 0, done = 0.
  - Reset asserted mid-operation aborts the run immediately; no done pulse.
- Outputs mux_sel, busy and done are Moore-decoded from state. mem_addr and sum are registers.
- IDLE:
  - mux_sel = 0; sum holds its last value.
  - start = 1 at a clock edge: len_q <= min(len, 2^ADDR_WIDTH); go to INIT.
- INIT (1 cycle):
  - mux_sel = 0; sum <= mux_out (zero); mem_addr <= 0; counter <= 0.
  - Next state: DONE if len_q == 0, else ACCUM.
- ACCUM:
  - mux_sel = 1; each cycle sum <= mux_out, counter <= counter + 1, mem_addr <= mem_addr + 1.
  - When counter == len_q - 1: load that final word and go to DONE.
  - At len_q = 2^ADDR_WIDTH the last address is 2^ADDR_WIDTH - 1. The address increment after it wraps to 0 and is unused.
- DONE (1 cycle):
  - done = 1, busy = 0, mux_sel = 0; sum holds.
  - Next state: IDLE.
- sum holds the result until the next INIT clears it.
- start asserted in INIT, ACCUM or DONE is ignored. It is not queued.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.
- len changes while busy have no effect (len_q is latched).
- Arithmetic is modulo 2^WIDTH; overflow silently wraps. The adder sits outside this block.
- Latency: start sampled at edge 0 → INIT after edge 0. ACCUM occupies len_q cycles. done is high in cycle len_q + 2, counting from the start edge. With len_q = 0, done is high in cycle 2.
- Unused state encodings return to IDLE.

Test Plan:
- Basic sum: mem[i] = i+1, len = 4, pulse start → mem_addr steps 0,1,2,3; mux_sel = 0 in INIT then 1 for 4 cycles; done pulses exactly once in cycle 6; sum = 10 and held for 5 further idle cycles.
- Zero length: len = 0, start → INIT then DONE; done in cycle 2; sum = 0 even though the previous sum was 10; mux_sel never 1.
- Full range and clamp: mem[i] = 1 for all 16 words, len = 16 → sum = 16, last mem_addr = 15. Repeat with len = 20 → sum = 16, done in cycle 18.
- Overflow: WIDTH = 32, mem[0] = mem[1] = 32'hFFFFFFFF, len = 2 → sum = 32'hFFFFFFFE, no error indication.
- Start while busy: a second start pulse, with len = 1, during ACCUM of a len = 4 run → ignored; one done only; sum = 10.
- Reset mid-run: assert rst_n low asynchronously (between clock edges) in the 2nd ACCUM cycle → sum = 0, mem_addr = 0, busy = 0, no done. After release, a fresh len = 4 run gives sum = 10.
